// File: rtl/timer_pkg.sv
// Shared types and defaults for the MM:SS countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_SEC_MAX = 59;
    localparam int DEF_MIN_MAX = 59;

endpackage

// File: rtl/mod_down_counter.sv
// Modulo-(MAX+1) up/down field counter with saturating load and borrow-out.
module mod_down_counter #(
    parameter int W   = 8,
    parameter int MAX = 59,
    parameter int RST = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         borrow
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] RST_V = W'(RST);

    logic [W-1:0] value_q, value_d;

    // load > dec > inc; decrement from zero wraps to MAX and raises borrow
    always_comb begin
        value_d = value_q;
        if (load)
            value_d = (load_val > MAX_V) ? MAX_V : load_val;
        else if (dec)
            value_d = (value_q == '0) ? MAX_V : value_q - W'(1);
        else if (inc)
            value_d = (value_q == MAX_V) ? '0 : value_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            value_q <= RST_V;
        else if (en)
            value_q <= value_d;
    end

    assign value  = value_q;
    assign borrow = dec && (value_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: run/pause FSM, preset load, manual adjust, done pulse.
// Optional AUTO_RELOAD_EN: reload the last preset on reaching 00:00 and keep running.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int W       = 8,
    parameter int SEC_MAX = DEF_SEC_MAX,
    parameter int MIN_MAX = DEF_MIN_MAX,
    parameter int RST_MIN = 0,
    parameter int RST_SEC = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         adj_tick,
    input  logic         start,
    input  logic         pause,
    input  logic         load,
    input  logic [W-1:0] load_min,
    input  logic [W-1:0] load_sec,
    input  logic         adj,
    input  logic         sel,
    output logic [W-1:0] minutes,
    output logic [W-1:0] seconds,
    output logic         running,
    output logic         done
);

    if (SEC_MAX >= 2**W || MIN_MAX >= 2**W || RST_MIN > MIN_MAX || RST_SEC > SEC_MAX) begin : g_bad_params
        $error("countdown_timer: illegal parameter combination");
    end

    state_t       state_q;
    logic         running_q, done_q;
    logic [W-1:0] min_v, sec_v;
    logic [W-1:0] ld_min, ld_sec;
    logic         cnt_zero, run_tick, hits_zero, start_go, adj_go, reload;
    logic         load_cnt, sec_borrow;

    assign cnt_zero  = (min_v == '0) && (sec_v == '0);
    assign run_tick  = !load && (state_q == ST_RUN) && !pause && tick && !cnt_zero;
    assign hits_zero = run_tick && (min_v == '0) && (sec_v == W'(1));
    assign start_go  = !load && (state_q == ST_IDLE) && start && !cnt_zero;
    assign adj_go    = !load && (state_q == ST_IDLE) && !start_go && adj && adj_tick;

`ifdef AUTO_RELOAD_EN
    localparam logic [W-1:0] MIN_MAX_V = W'(MIN_MAX);
    localparam logic [W-1:0] SEC_MAX_V = W'(SEC_MAX);

    logic [W-1:0] shadow_min_q, shadow_sec_q;

    // shadow holds the saturated preset, matching what the counters load
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_min_q <= W'(RST_MIN);
            shadow_sec_q <= W'(RST_SEC);
        end else if (load) begin
            shadow_min_q <= (load_min > MIN_MAX_V) ? MIN_MAX_V : load_min;
            shadow_sec_q <= (load_sec > SEC_MAX_V) ? SEC_MAX_V : load_sec;
        end
    end

    assign reload = hits_zero && ((shadow_min_q != '0) || (shadow_sec_q != '0));
    assign ld_min = load ? load_min : shadow_min_q;
    assign ld_sec = load ? load_sec : shadow_sec_q;
`else
    assign reload = 1'b0;
    assign ld_min = load_min;
    assign ld_sec = load_sec;
`endif

    assign load_cnt = load || reload;

    mod_down_counter #(.W(W), .MAX(SEC_MAX), .RST(RST_SEC)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .en       (load_cnt || run_tick || (adj_go && sel)),
        .load     (load_cnt),
        .load_val (ld_sec),
        .dec      (run_tick),
        .inc      (adj_go && sel),
        .value    (sec_v),
        .borrow   (sec_borrow)
    );

    mod_down_counter #(.W(W), .MAX(MIN_MAX), .RST(RST_MIN)) u_min (
        .clk      (clk),
        .rst      (rst),
        .en       (load_cnt || sec_borrow || (adj_go && !sel)),
        .load     (load_cnt),
        .load_val (ld_min),
        .dec      (sec_borrow),
        .inc      (adj_go && !sel),
        .value    (min_v),
        .borrow   ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (start_go) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                    ST_RUN: if (pause) begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                    end else if (hits_zero) begin
                        done_q <= 1'b1;
                        if (!reload) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                        end
                    end
                    ST_PAUSED: if (start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign minutes = min_v;
    assign seconds = sec_v;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer (default and AUTO_RELOAD_EN builds).
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0, tick = 1'b0, adj_tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic       load = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [7:0] load_min = '0, load_sec = '0;
    logic [7:0] minutes, seconds;
    logic       running, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    countdown_timer dut (
        .clk(clk), .rst(rst), .tick(tick), .adj_tick(adj_tick), .start(start),
        .pause(pause), .load(load), .load_min(load_min), .load_sec(load_sec),
        .adj(adj), .sel(sel), .minutes(minutes), .seconds(seconds),
        .running(running), .done(done)
    );

    typedef struct {
        logic       r, t, at, st, pa, ld, aj, sl;
        logic [7:0] lmin, lsec;
        logic [7:0] emin, esec;
        logic       erun, edone;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic t, logic at, logic st, logic pa, logic ld,
                                logic aj, logic sl, logic [7:0] lmin, logic [7:0] lsec,
                                logic [7:0] emin, logic [7:0] esec, logic erun, logic edone);
        vec_t v;
        v.r = r; v.t = t; v.at = at; v.st = st; v.pa = pa; v.ld = ld; v.aj = aj; v.sl = sl;
        v.lmin = lmin; v.lsec = lsec; v.emin = emin; v.esec = esec; v.erun = erun; v.edone = edone;
        return v;
    endfunction

    task automatic check(string nm, logic [7:0] emin, logic [7:0] esec, logic erun, logic edone);
        total++;
        if (minutes !== emin || seconds !== esec || running !== erun || done !== edone) begin
            bad++;
            $display("FAIL %s: got %0d:%0d run=%0b done=%0b, want %0d:%0d run=%0b done=%0b",
                     nm, minutes, seconds, running, done, emin, esec, erun, edone);
        end
    endtask

    task automatic drive(logic r, logic t, logic at, logic st, logic pa, logic ld,
                         logic aj, logic sl, logic [7:0] lm, logic [7:0] ls);
        rst = r; tick = t; adj_tick = at; start = st; pause = pa; load = ld;
        adj = aj; sel = sl; load_min = lm; load_sec = ls;
        @(posedge clk);
        #1;
        rst = 0; tick = 0; adj_tick = 0; start = 0; pause = 0; load = 0;
        adj = 0; sel = 0; load_min = '0; load_sec = '0;
    endtask

    task automatic do_rst();            drive(1,0,0,0,0,0,0,0,0,0);  endtask
    task automatic do_tick();           drive(0,1,0,0,0,0,0,0,0,0);  endtask
    task automatic do_start();          drive(0,0,0,1,0,0,0,0,0,0);  endtask
    task automatic do_idle();           drive(0,0,0,0,0,0,0,0,0,0);  endtask
    task automatic do_load(logic [7:0] m, logic [7:0] s); drive(0,0,0,0,0,1,0,0,m,s); endtask

    initial begin
        int m, s;
        logic exp_done;

        //                r t a s p l j s  lmin lsec  emin esec run done
        vecs.push_back(mk(1,0,0,0,0,0,0,0,  0,   0,    0,  59,  0, 0)); // reset
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,   0,    0,  59,  0, 0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,  0,   0,    0,  59,  0, 0)); // tick in IDLE ignored
        vecs.push_back(mk(0,0,0,1,0,0,0,0,  0,   0,    0,  59,  1, 0)); // start
        vecs.push_back(mk(0,1,0,0,0,0,0,0,  0,   0,    0,  58,  1, 0));
        vecs.push_back(mk(0,1,0,0,1,0,0,0,  0,   0,    0,  58,  0, 0)); // pause drops tick
        vecs.push_back(mk(0,1,0,0,0,0,0,0,  0,   0,    0,  58,  0, 0)); // paused: tick held
        vecs.push_back(mk(0,0,1,0,0,0,1,1,  0,   0,    0,  58,  0, 0)); // paused: adj ignored
        vecs.push_back(mk(0,0,0,1,1,0,0,0,  0,   0,    0,  58,  1, 0)); // start beats pause
        vecs.push_back(mk(0,0,0,0,0,1,0,0, 75,  99,   59,  59,  0, 0)); // saturating load
        vecs.push_back(mk(0,0,1,0,0,0,1,1,  0,   0,   59,   0,  0, 0)); // adj sec wraps
        vecs.push_back(mk(0,0,1,0,0,0,1,0,  0,   0,    0,   0,  0, 0)); // adj min wraps
        vecs.push_back(mk(0,0,0,1,0,0,0,0,  0,   0,    0,   0,  0, 0)); // start at 00:00
        vecs.push_back(mk(0,0,1,0,0,0,1,1,  0,   0,    0,   1,  0, 0));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,  0,   0,    0,   1,  1, 0));
`ifdef AUTO_RELOAD_EN
        vecs.push_back(mk(0,1,0,0,0,0,0,0,  0,   0,   59,  59,  1, 1)); // reload shadow
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,   0,   59,  59,  1, 0));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,  0,   0,   59,  59,  1, 0));
`else
        vecs.push_back(mk(0,1,0,0,0,0,0,0,  0,   0,    0,   0,  0, 1)); // reach 00:00
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,   0,    0,   0,  0, 0)); // done one clk
        vecs.push_back(mk(0,0,0,1,0,0,0,0,  0,   0,    0,   0,  0, 0)); // start in DONE
`endif
        vecs.push_back(mk(0,0,0,0,0,1,0,0,  2,   0,    2,   0,  0, 0));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,  0,   0,    2,   0,  1, 0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,  0,   0,    1,  59,  1, 0)); // borrow
        vecs.push_back(mk(0,0,0,0,0,1,0,0,  7,   7,    0,  59,  0, 0)); // load with rst
        vecs[vecs.size()-1].r = 1'b1;                                     // rst beats load

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].t, vecs[i].at, vecs[i].st, vecs[i].pa, vecs[i].ld,
                  vecs[i].aj, vecs[i].sl, vecs[i].lmin, vecs[i].lsec);
            check($sformatf("vec%0d", i), vecs[i].emin, vecs[i].esec, vecs[i].erun, vecs[i].edone);
        end

        // 59 ticks from reset value
        do_rst();
        do_start();
        check("t1_start", 0, 59, 1, 0);
        for (int i = 1; i <= 59; i++) begin
            do_tick();
`ifdef AUTO_RELOAD_EN
            if (i == 59) check("t1_tick", 0, 59, 1, 1);
            else         check("t1_tick", 0, 8'(59 - i), 1, 0);
`else
            check("t1_tick", 0, 8'(59 - i), (i < 59), (i == 59));
`endif
        end
        do_idle();
`ifdef AUTO_RELOAD_EN
        check("t1_after", 0, 59, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            do_tick();
            check("t1_more", 0, 8'(59 - i), 1, 0);
        end
`else
        check("t1_after", 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            do_tick();
            check("t1_hold", 0, 0, 0, 0);
        end
`endif

        // 02:00 full countdown
        do_rst();
        do_load(2, 0);
        do_start();
        check("t2_start", 2, 0, 1, 0);
        m = 2; s = 0;
        for (int i = 1; i <= 120; i++) begin
            if (s > 0) s--;
            else begin m--; s = 59; end
            exp_done = (m == 0 && s == 0);
            do_tick();
`ifdef AUTO_RELOAD_EN
            if (exp_done) check("t2_tick", 2, 0, 1, 1);
            else          check("t2_tick", 8'(m), 8'(s), 1, 0);
`else
            check("t2_tick", 8'(m), 8'(s), !exp_done, exp_done);
`endif
        end
`ifndef AUTO_RELOAD_EN
        do_tick();
        check("t2_floor", 0, 0, 0, 0);
`endif

        // pause with coincident tick, resume
        do_load(0, 10);
        do_start();
        drive(0,1,0,0,1,0,0,0,0,0);
        check("t3_pause", 0, 10, 0, 0);
        drive(0,0,0,1,1,0,0,0,0,0);
        check("t3_resume", 0, 10, 1, 0);
        do_tick();
        check("t3_tick", 0, 9, 1, 0);

        // reset mid-run, load after done
        do_load(0, 40);
        do_start();
        for (int i = 0; i < 10; i++) do_tick();
        check("t5_run", 0, 30, 1, 0);
        do_rst();
        check("t5_rst", 0, 59, 0, 0);
        do_load(0, 1);
        do_start();
        do_tick();
`ifdef AUTO_RELOAD_EN
        check("t5_done", 0, 1, 1, 1);
`else
        check("t5_done", 0, 0, 0, 1);
`endif
        do_load(3, 4);
        check("t5_load", 3, 4, 0, 0);

        // short preset, reload behaviour
        do_load(0, 3);
        do_start();
        for (int i = 0; i < 3; i++) do_tick();
`ifdef AUTO_RELOAD_EN
        check("t6_reload", 0, 3, 1, 1);
`else
        check("t6_done", 0, 0, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
